sq_drain: RTL and testbench
===========================

Name: sq_drain

Overview:
- Consumer end of the store queue. Drains committed stores from the SQ head to data memory, in program order.
- Counts stores the ROB has committed, waits until the head entry holds valid data, then latches address/data and issues a memory write via a req/ack handshake. On ack it pulses the delete strobe that pops the SQ head.
- Sits between the SQ storage, the commit logic and the data-memory write port.

Parameters:
- ADDR_W, 8, store address width (matches SQ addr field).
- DATA_W, 32, store data width.
- PC_W, 32, PC width carried for retire trace.
- CNT_W, 6, width of committed-store counter (SQ depth 64 -> max 63 pending).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- commit  in  1  one-cycle pulse per store committed by the ROB.
- head_valid_entry  in  1  SQ head entry allocated.
- head_valid_data  in  1  SQ head addr/data written by execute.
- head_pc  in  PC_W  PC of head store.
- head_addr  in  ADDR_W  head store address.
- head_data  in  DATA_W  head store data.
- mem_req  out  1  write request to data memory.
- mem_addr  out  ADDR_W  latched write address.
- mem_wdata  out  DATA_W  latched write data.
- mem_ack  in  1  memory accepted write (sampled while mem_req=1).
- del  out  1  one-cycle pop strobe to SQ head.
- retired_pc  out  PC_W  PC of last drained store.
- pending  out  CNT_W  committed-but-undrained count.
- busy  out  1  FSM not in IDLE.
- ovf  out  1  sticky: commit arrived with pending at max.

Behaviour:
- Reset (async, rst=1): state IDLE, pending=0, mem_req=0, mem_addr=0, mem_wdata=0, del=0, retired_pc=0, ovf=0. Reset asserted mid-transaction abandons it: no del, mem_req drops immediately.
- FSM states: IDLE, REQ, RETIRE.
- IDLE -> REQ when pending!=0 && head_valid_entry && head_valid_data. On that edge latch head_addr/head_data/head_pc into mem_addr/mem_wdata/pc_hold. With pending!=0 but head_valid_data=0, stay IDLE (stall, no request).
- REQ: mem_req=1 with stable mem_addr/mem_wdata. Stay until mem_ack=1 is sampled; on the ack edge -> RETIRE. mem_ack while not in REQ is ignored.
- RETIRE: del=1 for exactly this cycle, retired_pc<=pc_hold, pending decrements. Next state is IDLE.
- Minimum per-store latency from eligible head to del: 3 cycles with ack in the first REQ cycle. Back-to-back throughput is one store per 3 cycles. Never re-enters REQ before the del cycle has passed.
- Counter: next pending = pending + commit - (state==RETIRE).
  - Simultaneous commit and retire leave pending unchanged.
  - commit at pending==2^CNT_W-1 without a retire is dropped: count saturates and ovf sets (sticky until reset).
  - Decrement at pending==0 cannot occur, because RETIRE is only reachable with pending>=1.
- busy = (state!=IDLE). All outputs are registered. del and mem_req are never high in the same cycle.

Test Plan:
- Single store: commit pulse, head valid_entry=1, valid_data=1, addr=0x10, data=0xDEADBEEF; ack on first REQ cycle -> mem_req for 1 cycle with addr 0x10/data 0xDEADBEEF, del pulses 1 cycle later, retired_pc=head_pc, pending 1->0.
- Data-not-ready stall: commit with head_valid_data=0 for 5 cycles, then 1 -> no mem_req during stall; request starts the cycle after valid_data rises.
- Slow memory: mem_ack delayed 4 cycles -> mem_req held 5 cycles, addr/data stable even though head_* inputs change, single del.
- Burst: 3 commits on consecutive cycles, ack always 1 -> pending peaks at 3; three del pulses spaced 3 cycles apart; pending ends 0.
- Commit coincident with RETIRE -> pending unchanged that cycle. 64 commits with no drain (head invalid) -> pending=63, ovf=1.
- Reset asserted during REQ -> mem_req=0, pending=0, no del; after release, new commit drains normally.

Source files
------------

// File: rtl/sq_drain.sv
// sq_drain: store-queue drain, moves committed stores from the SQ head to
// data memory in program order through a req/ack write, then pops the head.
//
// Ports:
//   clk, rst             rising-edge clock, async active-high reset
//   commit               one-cycle pulse per store committed by the ROB
//   head_valid_entry     SQ head entry allocated
//   head_valid_data      SQ head addr/data written
//   head_pc/addr/data    SQ head store fields
//   mem_req/addr/wdata   write request to data memory (registered)
//   mem_ack              memory accepted the write (only looked at in REQ)
//   del                  one-cycle pop strobe to the SQ head
//   retired_pc           PC of the last drained store
//   pending              committed-but-undrained store count
//   busy                 a store is in flight
//   ovf                  sticky: commit arrived with pending saturated
module sq_drain #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit,
    input  logic              head_valid_entry,
    input  logic              head_valid_data,
    input  logic [PC_W-1:0]   head_pc,
    input  logic [ADDR_W-1:0] head_addr,
    input  logic [DATA_W-1:0] head_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    output logic              del,
    output logic [PC_W-1:0]   retired_pc,
    output logic [CNT_W-1:0]  pending,
    output logic              busy,
    output logic              ovf
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RETIRE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state;
    state_t             state_n;
    logic [PC_W-1:0]    pc_hold;
    logic               start;
    logic               retire;
    logic [CNT_W-1:0]   pending_n;
    logic               ovf_set;

    assign retire = (state == RETIRE);

    always_comb begin
        state_n = state;
        start   = 1'b0;
        unique case (state)
            IDLE: begin
                if (pending != '0 && head_valid_entry && head_valid_data) begin
                    state_n = REQ;
                    start   = 1'b1;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_n = RETIRE;
                end
            end
            RETIRE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // A commit that coincides with a retire cancels out; a commit that
    // would wrap the counter is dropped and flagged instead.
    always_comb begin
        pending_n = pending;
        ovf_set   = 1'b0;
        if (commit && !retire) begin
            if (pending == CNT_MAX) begin
                ovf_set = 1'b1;
            end else begin
                pending_n = pending + CNT_ONE;
            end
        end else if (!commit && retire) begin
            pending_n = pending - CNT_ONE;
        end
    end

    // Strobes are decoded from the next state so they are true flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= '0;
            ovf        <= 1'b0;
            mem_req    <= 1'b0;
            del        <= 1'b0;
            busy       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            pc_hold    <= '0;
            retired_pc <= '0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            ovf     <= ovf | ovf_set;
            mem_req <= (state_n == REQ);
            del     <= (state_n == RETIRE);
            busy    <= (state_n != IDLE);
            if (start) begin
                mem_addr  <= head_addr;
                mem_wdata <= head_data;
                pc_hold   <= head_pc;
            end
            if (retire) begin
                retired_pc <= pc_hold;
            end
        end
    end

endmodule

// File: tb/tb_sq_drain.sv
// tb_sq_drain: directed bench for sq_drain with a store-lifecycle model
// checked every cycle plus literal expectations per scenario.
module tb_sq_drain;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        commit = 1'b0;
    logic        hve = 1'b0;
    logic        hvd = 1'b0;
    logic [31:0] head_pc = '0;
    logic [7:0]  head_addr = '0;
    logic [31:0] head_data = '0;
    logic        mem_ack = 1'b0;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        del;
    logic [31:0] retired_pc;
    logic [5:0]  pending;
    logic        busy;
    logic        ovf;

    sq_drain #(
        .ADDR_W(8),
        .DATA_W(32),
        .PC_W(32),
        .CNT_W(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .commit(commit),
        .head_valid_entry(hve),
        .head_valid_data(hvd),
        .head_pc(head_pc),
        .head_addr(head_addr),
        .head_data(head_data),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack),
        .del(del),
        .retired_pc(retired_pc),
        .pending(pending),
        .busy(busy),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Model: a store leaves the queue when it is committed and its head
    // is complete; it spends one cycle requesting per un-acked cycle, then
    // a single pop cycle, after which the count drops and the PC retires.
    int          m_pend = 0;
    int          m_old;
    bit          m_ovf = 0;
    bit          m_in_flight = 0;
    bit          m_popping = 0;
    logic [7:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_rpc = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = 0;
            m_ovf = 0;
            m_in_flight = 0;
            m_popping = 0;
            m_addr = '0;
            m_data = '0;
            m_pc = '0;
            m_rpc = '0;
        end else begin
            m_old = m_pend;
            m_pend = m_old + (commit ? 1 : 0) - (m_popping ? 1 : 0);
            if (m_pend > 63) begin
                m_pend = 63;
                m_ovf = 1;
            end
            if (m_popping) begin
                m_rpc = m_pc;
                m_popping = 0;
            end else if (m_in_flight) begin
                if (mem_ack) begin
                    m_in_flight = 0;
                    m_popping = 1;
                end
            end else if (m_old > 0 && hve && hvd) begin
                m_in_flight = 1;
                m_addr = head_addr;
                m_data = head_data;
                m_pc = head_pc;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("mem_req", mem_req, m_in_flight);
            chk("del", del, m_popping);
            chk("busy", busy, m_in_flight | m_popping);
            chk("pending", pending, m_pend[5:0]);
            chk("ovf", ovf, m_ovf);
            chk("retired_pc", retired_pc, m_rpc);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_data);
            chk("req_del_excl", mem_req & del, 1'b0);
        end
    end

    int cyc = 0;
    int req_cnt = 0;
    int del_cnt = 0;
    int last_del = 0;
    int prev_del = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (mem_req) req_cnt++;
            if (del) begin
                del_cnt++;
                prev_del = last_del;
                last_del = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    int r0;
    int d0;

    initial begin
        tick();
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_pending", pending, 6'd0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_retired_pc", retired_pc, 32'h0);
        tick();
        rst = 1'b0;

        // Single store, immediate ack.
        hve = 1'b1;
        hvd = 1'b1;
        head_pc = 32'h1000;
        head_addr = 8'h10;
        head_data = 32'hDEADBEEF;
        mem_ack = 1'b1;
        r0 = req_cnt;
        d0 = del_cnt;
        pulse_commit();
        repeat (6) tick();
        chk("single_req_cycles", req_cnt - r0, 1);
        chk("single_del", del_cnt - d0, 1);
        chk("single_addr", mem_addr, 8'h10);
        chk("single_data", mem_wdata, 32'hDEADBEEF);
        chk("single_rpc", retired_pc, 32'h1000);
        chk("single_pending", pending, 6'd0);

        // Data-not-ready stall.
        hvd = 1'b0;
        head_pc = 32'h1100;
        head_addr = 8'h11;
        head_data = 32'h11111111;
        r0 = req_cnt;
        d0 = del_cnt;
        pulse_commit();
        repeat (5) tick();
        chk("stall_no_req", req_cnt - r0, 0);
        chk("stall_pending", pending, 6'd1);
        hvd = 1'b1;
        chk("stall_req_low", mem_req, 1'b0);
        tick();
        chk("stall_req_next", mem_req, 1'b1);
        repeat (5) tick();
        chk("stall_del", del_cnt - d0, 1);

        // Slow memory: four un-acked REQ cycles then the ack.
        mem_ack = 1'b0;
        head_pc = 32'h2000;
        head_addr = 8'h20;
        head_data = 32'h12345678;
        r0 = req_cnt;
        d0 = del_cnt;
        pulse_commit();
        tick();
        head_pc = 32'h2F00;
        head_addr = 8'h99;
        head_data = 32'h99999999;
        repeat (4) tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        repeat (4) tick();
        chk("slow_req_cycles", req_cnt - r0, 5);
        chk("slow_del", del_cnt - d0, 1);
        chk("slow_addr_held", mem_addr, 8'h20);
        chk("slow_data_held", mem_wdata, 32'h12345678);
        chk("slow_rpc", retired_pc, 32'h2000);

        // Burst of three commits, ack always high.
        mem_ack = 1'b1;
        head_pc = 32'h3000;
        head_addr = 8'h30;
        head_data = 32'h30303030;
        d0 = del_cnt;
        commit = 1'b1;
        repeat (3) tick();
        chk("burst_peak", pending, 6'd3);
        commit = 1'b0;
        repeat (12) tick();
        chk("burst_dels", del_cnt - d0, 3);
        chk("burst_spacing", last_del - prev_del, 3);
        chk("burst_pending", pending, 6'd0);

        // Commit coincident with the pop cycle.
        pulse_commit();
        tick();
        tick();
        chk("coinc_del", del, 1'b1);
        chk("coinc_pend_before", pending, 6'd1);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("coinc_pend_after", pending, 6'd1);
        repeat (6) tick();
        chk("coinc_drained", pending, 6'd0);

        // Saturation with the head never valid.
        hve = 1'b0;
        commit = 1'b1;
        repeat (64) tick();
        commit = 1'b0;
        chk("ovf_pending", pending, 6'd63);
        chk("ovf_flag", ovf, 1'b1);
        tick();
        chk("ovf_sticky", ovf, 1'b1);

        // Reset in the middle of a request.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hve = 1'b1;
        mem_ack = 1'b0;
        head_pc = 32'h3300;
        head_addr = 8'h33;
        head_data = 32'hCAFEF00D;
        pulse_commit();
        tick();
        chk("rreq_active", mem_req, 1'b1);
        d0 = del_cnt;
        rst = 1'b1;
        #1;
        chk("rreq_drop", mem_req, 1'b0);
        chk("rreq_pending", pending, 6'd0);
        chk("rreq_ovf", ovf, 1'b0);
        tick();
        rst = 1'b0;
        chk("rreq_no_del", del_cnt - d0, 0);
        mem_ack = 1'b1;
        head_pc = 32'h4000;
        head_addr = 8'h40;
        head_data = 32'h40404040;
        pulse_commit();
        repeat (6) tick();
        chk("rreq_after_del", del_cnt - d0, 1);
        chk("rreq_after_rpc", retired_pc, 32'h4000);
        chk("rreq_after_pend", pending, 6'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
